// File: rtl/systolic_fifo_bank_pkg.sv
// Shared CNN parameter package: default array geometry and helpers
// used by the systolic array and its input FIFO bank.
package systolic_fifo_bank_pkg;

    localparam int CNN_DATA_SIZE  = 8;
    localparam int CNN_FIFO_DEPTH = 16;
    localparam int CNN_ARRAY_SIZE = 3;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/systolic_fifo_bank_skew_line.sv
// Per-channel delay line that staggers one FIFO channel in time
// so that rows enter the systolic array on a diagonal wavefront.
module skew_line
    import systolic_fifo_bank_pkg::*;
#(
    parameter int DATA_SIZE = CNN_DATA_SIZE,
    parameter int DELAY     = 0
) (
    input  logic                 s_clk,
    input  logic                 clear_n,
    input  logic                 flush,
    input  logic                 d_valid,
    input  logic [DATA_SIZE-1:0] d_data,
    output logic                 q_valid,
    output logic [DATA_SIZE-1:0] q_data
);

    generate
        if (DELAY == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{s_clk, clear_n, flush};
            assign q_valid     = d_valid;
            assign q_data      = d_data;
        end else begin : g_pipe
            logic [DELAY-1:0]     v_pipe;
            logic [DATA_SIZE-1:0] d_pipe [DELAY];

            always_ff @(posedge s_clk or negedge clear_n) begin
                if (!clear_n) begin
                    v_pipe <= '0;
                    for (int k = 0; k < DELAY; k++) begin
                        d_pipe[k] <= '0;
                    end
                end else if (flush) begin
                    v_pipe <= '0;
                    for (int k = 0; k < DELAY; k++) begin
                        d_pipe[k] <= '0;
                    end
                end else begin
                    v_pipe[0] <= d_valid;
                    d_pipe[0] <= d_data;
                    for (int k = 1; k < DELAY; k++) begin
                        v_pipe[k] <= v_pipe[k-1];
                        d_pipe[k] <= d_pipe[k-1];
                    end
                end
            end

            assign q_valid = v_pipe[DELAY-1];
            assign q_data  = d_pipe[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_fifo_bank.sv
// Lockstep multi-channel FIFO feeding the systolic array rows,
// with a registered read stage and optional diagonal output skew.
module systolic_fifo_bank
    import systolic_fifo_bank_pkg::*;
#(
    parameter int DATA_SIZE  = CNN_DATA_SIZE,
    parameter int FIFO_DEPTH = CNN_FIFO_DEPTH,
    parameter int ARRAY_SIZE = CNN_ARRAY_SIZE,
    parameter int SKEW_EN    = 1
) (
    input  logic                             s_clk,
    input  logic                             clear_n,
    input  logic                             flush,
    input  logic                             w_en,
    input  logic [ARRAY_SIZE*DATA_SIZE-1:0]  dataIn,
    input  logic                             r_en,
    output logic [ARRAY_SIZE*DATA_SIZE-1:0]  dataOut,
    output logic [ARRAY_SIZE-1:0]            valid_out,
    output logic                             full,
    output logic                             empty,
    output logic [clog2(FIFO_DEPTH):0]       level,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int W  = ARRAY_SIZE * DATA_SIZE;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_next;
    logic          wr_go;
    logic          rd_go;
    logic          st_valid;
    logic [W-1:0]  st_data;

    // Write at full is allowed only because a read frees a slot the same
    // cycle; read at empty never falls through to the incoming word.
    always_comb begin
        wr_go      = w_en && (!full || r_en) && !flush;
        rd_go      = r_en && !empty && !flush;
        level_next = level;
        if (wr_go && !rd_go) begin
            level_next = level + (AW+1)'(1);
        end else if (rd_go && !wr_go) begin
            level_next = level - (AW+1)'(1);
        end
    end

    always_ff @(posedge s_clk) begin
        if (wr_go) begin
            mem[wr_ptr] <= dataIn;
        end
    end

    always_ff @(posedge s_clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            st_valid  <= 1'b0;
            st_data   <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            st_valid  <= 1'b0;
        end else begin
            if (wr_go) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_go) begin
                rd_ptr  <= rd_ptr + AW'(1);
                st_data <= mem[rd_ptr];
            end
            st_valid  <= rd_go;
            level     <= level_next;
            full      <= (level_next == DEPTH_L);
            empty     <= (level_next == '0);
            overflow  <= overflow | (w_en && full && !r_en);
            underflow <= underflow | (r_en && empty && !w_en);
        end
    end

    generate
        for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_ch
            skew_line #(
                .DATA_SIZE (DATA_SIZE),
                .DELAY     ((SKEW_EN != 0) ? i : 0)
            ) u_skew (
                .s_clk   (s_clk),
                .clear_n (clear_n),
                .flush   (flush),
                .d_valid (st_valid),
                .d_data  (st_data[i*DATA_SIZE +: DATA_SIZE]),
                .q_valid (valid_out[i]),
                .q_data  (dataOut[i*DATA_SIZE +: DATA_SIZE])
            );
        end
    endgenerate

endmodule

// File: tb/tb_systolic_fifo_bank.sv
// Directed bench: skewed and aligned banks driven with identical
// stimulus, expected values hand-computed per scenario.
module tb_systolic_fifo_bank;

    logic        s_clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        flush = 1'b0;
    logic        w_en = 1'b0;
    logic        r_en = 1'b0;
    logic [23:0] dataIn = '0;

    logic [23:0] dataOut, dataOut_a;
    logic [2:0]  valid_out, valid_out_a;
    logic        full, empty, overflow, underflow;
    logic        full_a, empty_a, overflow_a, underflow_a;
    logic [2:0]  level, level_a;

    int checks = 0;
    int errors = 0;

    always #5 s_clk = ~s_clk;

    systolic_fifo_bank #(
        .DATA_SIZE(8), .FIFO_DEPTH(4), .ARRAY_SIZE(3), .SKEW_EN(1)
    ) u_dut (
        .s_clk(s_clk), .clear_n(clear_n), .flush(flush),
        .w_en(w_en), .dataIn(dataIn), .r_en(r_en),
        .dataOut(dataOut), .valid_out(valid_out),
        .full(full), .empty(empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    systolic_fifo_bank #(
        .DATA_SIZE(8), .FIFO_DEPTH(4), .ARRAY_SIZE(3), .SKEW_EN(0)
    ) u_dut_a (
        .s_clk(s_clk), .clear_n(clear_n), .flush(flush),
        .w_en(w_en), .dataIn(dataIn), .r_en(r_en),
        .dataOut(dataOut_a), .valid_out(valid_out_a),
        .full(full_a), .empty(empty_a), .level(level_a),
        .overflow(overflow_a), .underflow(underflow_a)
    );

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        step();
        step();
        checks++;
        if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: level=%0d empty=%b full=%b, want 0 1 0",
                     level, empty, full);
        end
        checks++;
        if (valid_out !== 3'b000 || dataOut !== 24'h0) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h, want 000 000000",
                     valid_out, dataOut);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b unf=%b, want 0 0",
                     overflow, underflow);
        end
        clear_n = 1'b1;
    endtask

    task automatic test_latency();
        dataIn = 24'h030201;
        w_en = 1'b1;
        step();
        w_en = 1'b0;
        checks++;
        if (level !== 3'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL lat_level: level=%0d empty=%b, want 1 0", level, empty);
        end
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        checks++;
        if (valid_out !== 3'b001 || dataOut[7:0] !== 8'h01) begin
            errors++;
            $display("FAIL lat_ch0: valid=%b d0=%h, want 001 01",
                     valid_out, dataOut[7:0]);
        end
        checks++;
        if (valid_out_a !== 3'b111 || dataOut_a !== 24'h030201) begin
            errors++;
            $display("FAIL lat_aligned: valid=%b data=%h, want 111 030201",
                     valid_out_a, dataOut_a);
        end
        checks++;
        if (empty !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL lat_empty: empty=%b level=%0d, want 1 0", empty, level);
        end
        step();
        checks++;
        if (valid_out !== 3'b010 || dataOut[15:8] !== 8'h02) begin
            errors++;
            $display("FAIL lat_ch1: valid=%b d1=%h, want 010 02",
                     valid_out, dataOut[15:8]);
        end
        checks++;
        if (valid_out_a !== 3'b000) begin
            errors++;
            $display("FAIL lat_aligned_off: valid=%b, want 000", valid_out_a);
        end
        step();
        checks++;
        if (valid_out !== 3'b100 || dataOut[23:16] !== 8'h03) begin
            errors++;
            $display("FAIL lat_ch2: valid=%b d2=%h, want 100 03",
                     valid_out, dataOut[23:16]);
        end
        step();
        checks++;
        if (valid_out !== 3'b000) begin
            errors++;
            $display("FAIL lat_drain: valid=%b, want 000", valid_out);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        w_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = 8'h11 + 8'(i);
            dataIn = {e, e, e};
            step();
            if (i == 3) begin
                checks++;
                if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_fill: full=%b level=%0d ovf=%b, want 1 4 0",
                             full, level, overflow);
                end
            end
        end
        w_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 3'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: ovf=%b level=%0d full=%b, want 1 4 1",
                     overflow, level, full);
        end
        r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = 8'h11 + 8'(i);
            step();
            checks++;
            if (valid_out[0] !== 1'b1 || dataOut[7:0] !== e) begin
                errors++;
                $display("FAIL ovf_read%0d: v0=%b d0=%h, want 1 %h",
                         i, valid_out[0], dataOut[7:0], e);
            end
        end
        r_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || level !== 3'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: empty=%b level=%0d unf=%b, want 1 0 0",
                     empty, level, underflow);
        end
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (overflow !== 1'b0 || valid_out !== 3'b000) begin
            errors++;
            $display("FAIL ovf_flush: ovf=%b valid=%b, want 0 000",
                     overflow, valid_out);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] e;
        w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = 8'h21 + 8'(i);
            dataIn = {e, e, e};
            step();
        end
        r_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = 8'h25 + 8'(i);
            dataIn = {e, e, e};
            step();
            e = 8'h21 + 8'(i);
            checks++;
            if (level !== 3'd4 || full !== 1'b1 || valid_out[0] !== 1'b1 ||
                dataOut[7:0] !== e) begin
                errors++;
                $display("FAIL fullrw%0d: level=%0d full=%b v0=%b d0=%h, want 4 1 1 %h",
                         i, level, full, valid_out[0], dataOut[7:0], e);
            end
        end
        w_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = 8'h27 + 8'(i);
            step();
            checks++;
            if (valid_out[0] !== 1'b1 || dataOut[7:0] !== e) begin
                errors++;
                $display("FAIL wrap_read%0d: v0=%b d0=%h, want 1 %h",
                         i, valid_out[0], dataOut[7:0], e);
            end
        end
        r_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: empty=%b ovf=%b, want 1 0", empty, overflow);
        end
        step();
        step();
    endtask

    task automatic test_empty_rw();
        dataIn = 24'h313131;
        w_en = 1'b1;
        r_en = 1'b1;
        step();
        w_en = 1'b0;
        r_en = 1'b0;
        checks++;
        if (level !== 3'd1 || empty !== 1'b0 || valid_out !== 3'b000 ||
            underflow !== 1'b0) begin
            errors++;
            $display("FAIL empty_rw: level=%0d empty=%b valid=%b unf=%b, want 1 0 000 0",
                     level, empty, valid_out, underflow);
        end
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        checks++;
        if (valid_out[0] !== 1'b1 || dataOut[7:0] !== 8'h31) begin
            errors++;
            $display("FAIL empty_rw_read: v0=%b d0=%h, want 1 31",
                     valid_out[0], dataOut[7:0]);
        end
        step();
        step();
    endtask

    task automatic test_underflow();
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        checks++;
        if (underflow !== 1'b1 || valid_out !== 3'b000 || level !== 3'd0) begin
            errors++;
            $display("FAIL unf_set: unf=%b valid=%b level=%0d, want 1 000 0",
                     underflow, valid_out, level);
        end
        flush = 1'b1;
        w_en = 1'b1;
        dataIn = 24'h777777;
        step();
        flush = 1'b0;
        w_en = 1'b0;
        checks++;
        if (underflow !== 1'b0 || level !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL unf_flush: unf=%b level=%0d empty=%b, want 0 0 1",
                     underflow, level, empty);
        end
    endtask

    task automatic test_reset_mid_skew();
        dataIn = 24'h0C0B0A;
        w_en = 1'b1;
        step();
        w_en = 1'b0;
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        step();
        checks++;
        if (valid_out !== 3'b010 || dataOut[15:8] !== 8'h0B) begin
            errors++;
            $display("FAIL mid_pre: valid=%b d1=%h, want 010 0B",
                     valid_out, dataOut[15:8]);
        end
        #2;
        clear_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 3'b000 || dataOut !== 24'h0 || level !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b data=%h level=%0d, want 000 000000 0",
                     valid_out, dataOut, level);
        end
        checks++;
        if (valid_out_a !== 3'b000 || dataOut_a !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset_a: valid=%b data=%h, want 000 000000",
                     valid_out_a, dataOut_a);
        end
        @(posedge s_clk);
        #1;
        clear_n = 1'b1;
        dataIn = 24'h0F0E0D;
        w_en = 1'b1;
        step();
        w_en = 1'b0;
        checks++;
        if (level !== 3'd1 || valid_out !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_wr: level=%0d valid=%b, want 1 000",
                     level, valid_out);
        end
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        checks++;
        if (valid_out_a !== 3'b111 || dataOut_a !== 24'h0F0E0D) begin
            errors++;
            $display("FAIL aligned_lat: valid=%b data=%h, want 111 0F0E0D",
                     valid_out_a, dataOut_a);
        end
        checks++;
        if (valid_out !== 3'b001 || dataOut[7:0] !== 8'h0D) begin
            errors++;
            $display("FAIL skew_after_reset: valid=%b d0=%h, want 001 0D",
                     valid_out, dataOut[7:0]);
        end
        step();
        checks++;
        if (valid_out_a !== 3'b000 || valid_out !== 3'b010) begin
            errors++;
            $display("FAIL aligned_off: a=%b s=%b, want 000 010",
                     valid_out_a, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_underflow();
        test_reset_mid_skew();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_fifo_bank.md
SYSTOLIC_FIFO_BANK -- requirements
Module: systolic_fifo_bank

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, width of one element.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per channel, power of two, at least 2.
REQ-003 SHALL have parameter ARRAY_SIZE, default 3, number of channels (systolic rows).
REQ-004 SHALL have parameter SKEW_EN, default 1; 1 = diagonal output skew, 0 = aligned output.
REQ-005 SHALL have port s_clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port clear_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous soft clear of pointers, level and skew lines.
REQ-008 SHALL have port w_en  input  1  push one element into every channel.
REQ-009 SHALL have port dataIn  input  ARRAY_SIZE*DATA_SIZE  channel i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-010 SHALL have port r_en  input  1  pop one element from every channel.
REQ-011 SHALL have port dataOut  output  ARRAY_SIZE*DATA_SIZE  registered channel outputs, same packing.
REQ-012 SHALL have port valid_out  output  ARRAY_SIZE  per-channel qualifier for dataOut.
REQ-013 SHALL have port full, empty  output  1 each  shared bank status.
REQ-014 SHALL have port level  output  log2(FIFO_DEPTH)+1  current occupancy.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 All channels SHALL share one write pointer, one read pointer and one level counter, so they stay in lockstep.
REQ-017 Write accepted: w_en=1 and (full=0 or r_en=1); dataIn stored at the write pointer, pointer increments modulo FIFO_DEPTH.
REQ-018 Read accepted: r_en=1 and empty=0; read pointer increments modulo FIFO_DEPTH.
REQ-019 Level SHALL increment on write-only, decrement on read-only, and hold on simultaneous accepted read and write.
REQ-020 full SHALL be 1 exactly when level==FIFO_DEPTH; empty SHALL be 1 exactly when level==0. Both are registered and consistent with level in the same cycle.
REQ-021 At full with w_en=1 and r_en=1, both SHALL be accepted; level stays FIFO_DEPTH.
REQ-022 At empty with w_en=1 and r_en=1, only the write SHALL be accepted (no fall-through); level becomes 1.
REQ-023 A write at full without a read SHALL be dropped and set overflow; a read at empty SHALL be ignored and set underflow. Both flags hold until reset or flush.
REQ-024 Read latency SHALL be 1 cycle: the popped entry appears on the pre-skew stage the cycle after the accepted read, with stage valid=1; otherwise stage valid=0 and stage data holds.
REQ-025 With SKEW_EN=1, channel i output SHALL be the pre-skew stage delayed by i further cycles (channel 0 latency 1, channel i latency 1+i), with valid_out[i] delayed identically.
REQ-026 With SKEW_EN=0, all channels SHALL have latency 1 and valid_out SHALL be all-ones or all-zeros.
REQ-027 flush SHALL take priority over w_en and r_en in the same cycle. Next cycle: pointers=0, level=0, empty=1, full=0, valid_out=0, error flags=0. Storage contents are not cleared.
REQ-028 Pointer wrap-around SHALL be seamless: data order is preserved across the FIFO_DEPTH boundary.

Reset
REQ-029 clear_n=0 SHALL immediately force pointers=0, level=0, empty=1, full=0, overflow=0, underflow=0, valid_out=0 and dataOut=0, including the skew registers.
REQ-030 Storage RAM SHALL NOT be reset; reset may be asserted mid-operation, and in-flight skewed data is discarded.
REQ-031 Deassertion SHALL be used synchronously; the first write is accepted on the first rising edge with clear_n=1.

Structure
REQ-032 DATA_SIZE, ARRAY_SIZE and FIFO_DEPTH defaults, plus a clog2 helper function, SHALL live in the shared CNN parameter package, which the systolic array also uses.
REQ-033 The per-channel delay line SHALL be a sub-module skew_line (parameters DATA_SIZE and DELAY; DELAY=0 is a passthrough), instantiated ARRAY_SIZE times via generate.
REQ-034 Storage SHALL be one array of ARRAY_SIZE*DATA_SIZE-wide words, FIFO_DEPTH deep, inferable as RAM.

Verification (DATA_SIZE=8, FIFO_DEPTH=4, ARRAY_SIZE=3, SKEW_EN=1)
REQ-035 Reset, then write 0x030201 and read once -> channel 0 = 0x01 valid at read+1, channel 1 = 0x02 valid at read+2, channel 2 = 0x03 valid at read+3.
REQ-036 Write 5 words without reading -> full=1 after the 4th, 5th dropped, overflow=1, level=4; then read 4 -> words 1-4 in order, empty=1.
REQ-037 At full, assert w_en and r_en for 6 cycles with incrementing data -> level stays 4, output order is unbroken across pointer wrap.
REQ-038 At empty, assert w_en and r_en together -> level=1, no valid_out for that cycle's read, underflow stays 0.
REQ-039 r_en on empty bank -> underflow=1, valid_out=0; then flush -> underflow=0, level=0.
REQ-040 Assert clear_n=0 mid-skew (channel 2 pending) -> valid_out=0 and dataOut=0 immediately; rerun with SKEW_EN=0 -> all channels valid together at latency 1.
